microseq_ctl: RTL
=================

// Module: microseq_ctl
// PURPOSE
//  Parametrised microprogram sequencer; next generation of the three-slice 2909/2911 cascade.
//  Generates the microcode ROM address each cycle from the pipeline register's branch field,
//  condition flags, a subroutine stack, a loop counter and an address register.
//  y drives the CodeROM combinationally; the external pipeline register captures ROM data.
// PARAMETERS
//  ADDR_W      11      microaddress width (y, din, rin, orin, uPC, stack, counter)
//  STACK_DEPTH 4       subroutine stack entries (>=1)
//  COND_W      8       number of condition inputs
//  RESET_ADDR  0       y value during reset and first fetch after release
//  FETCH_ADDR  11'h101 instruction-start address (perf counter only)
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high
//  op          in   4       next-address opcode (pipeline field)
//  din         in   ADDR_W  branch address / counter load value
//  rin         in   ADDR_W  address-register load source (FBus)
//  orin        in   ADDR_W  OR-mask applied to y (case branches)
//  conds       in   COND_W  condition flags (e.g. registered alu_zero)
//  cond_sel    in   $clog2(COND_W)  selects conds bit
//  cond_pol    in   1       1 = invert selected condition
//  hold        in   1       freeze: y repeats, no state change
//  y           out  ADDR_W  microcode ROM address (combinational)
//  stk_err     out  1       sticky stack overflow/underflow flag
// BEHAVIOUR
//  State: uPC, sp (0..STACK_DEPTH), stack[], cnt, ar, y_last, stk_err.
//  Reset (async): uPC=RESET_ADDR+1, sp=0, cnt=0, ar=0, y_last=RESET_ADDR, stk_err=0; y=RESET_ADDR.
//  c = conds[cond_sel] ^ cond_pol. y = sel | orin; uPC <= y+1 mod 2^ADDR_W; y_last <= y.
//  op 0 CONT : sel=uPC
//  op 1 JMP  : sel=din
//  op 2 CJMP : sel = c ? din : uPC
//  op 3 CALL : if c: sel=din, push uPC; else sel=uPC
//  op 4 RET  : if c: sel=stack[sp-1], pop; else sel=uPC
//  op 5 LDCNT: sel=uPC, cnt<=din
//  op 6 LOOP : cnt!=0: sel=din, cnt<=cnt-1; cnt==0: sel=uPC, cnt unchanged
//  op 7 JREG : sel=ar
//  op 8 LDAR : sel=uPC, ar<=rin
//  op 9 CJREG: sel = c ? ar : uPC
//  op 10-15  : treated as CONT
//  Pushed value is uPC before update (return to instruction after CALL).
//  Push at sp==STACK_DEPTH: no write, sp unchanged, stk_err<=1, jump still taken.
//  Pop at sp==0: sel=RESET_ADDR, sp stays 0, stk_err<=1.
//  hold=1: y=y_last, all registers unchanged (orin not re-applied); overrides op.
//  stk_err cleared only by reset. Latency: op->y same cycle; state updates on next edge.
//  Reset asserted mid-op: y forced to RESET_ADDR immediately; stack contents discarded.
// CONFIGURATION
//  MICROSEQ_PERF_EN defined: adds output instr_cycles[31:0]. Each edge with hold=0:
//   y==FETCH_ADDR -> instr_cycles<=1, else instr_cycles<=instr_cycles+1 (wraps); held on hold=1;
//   reset value 0. Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset, op=CONT x3 -> y=0,1,2,3; assert reset mid-run -> y=0 same cycle.
//  CALL din=0x40 (c=1) at y=0x10, RET (c=1) at 0x40 -> y=0x40 then 0x11; sp back to 0.
//  LDCNT din=3, then LOOP din=0x20 repeatedly -> taken 3 times, 4th falls through to uPC.
//  5 CALLs with STACK_DEPTH=4 -> stk_err=1 on 5th, jump taken; RET on empty -> y=RESET_ADDR.
//  CJMP cond_pol=1 with selected cond=1 -> not taken; orin=0x003 on JMP 0x100 -> y=0x103.
//  PERF_EN: jump to 0x101 every 4th cycle -> instr_cycles sequence 1,2,3,4,1; hold freezes count.

Source files
------------

// File: rtl/microseq_if.sv
// Next-address control bundle between the pipeline register and the microsequencer.
// MICROSEQ_PERF_EN adds the instr_cycles performance counter output.
interface microseq_if #(
  parameter int ADDR_W = 11,
  parameter int COND_W = 8
);
  localparam int SEL_W = (COND_W > 1) ? $clog2(COND_W) : 1;

  logic [3:0]        op;
  logic [ADDR_W-1:0] din;
  logic [ADDR_W-1:0] rin;
  logic [ADDR_W-1:0] orin;
  logic [COND_W-1:0] conds;
  logic [SEL_W-1:0]  cond_sel;
  logic              cond_pol;
  logic              hold;
  logic [ADDR_W-1:0] y;
  logic              stk_err;
`ifdef MICROSEQ_PERF_EN
  logic [31:0]       instr_cycles;
`endif

  modport master (
    output op, din, rin, orin, conds, cond_sel, cond_pol, hold,
`ifdef MICROSEQ_PERF_EN
    input  instr_cycles,
`endif
    input  y, stk_err
  );

  modport slave (
    input  op, din, rin, orin, conds, cond_sel, cond_pol, hold,
`ifdef MICROSEQ_PERF_EN
    output instr_cycles,
`endif
    output y, stk_err
  );
endinterface

// File: rtl/microseq_ctl.sv
// Microprogram sequencer: produces the CodeROM address each cycle from opcode, condition,
// subroutine stack, loop counter and address register. MICROSEQ_PERF_EN adds instr_cycles.
module microseq_ctl #(
  parameter int              ADDR_W      = 11,
  parameter int              STACK_DEPTH = 4,
  parameter int              COND_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] FETCH_ADDR = 11'h101
) (
  input  logic       clock,
  input  logic       reset,
  microseq_if.slave  bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_CONT  = 4'd0,
    OP_JMP   = 4'd1,
    OP_CJMP  = 4'd2,
    OP_CALL  = 4'd3,
    OP_RET   = 4'd4,
    OP_LDCNT = 4'd5,
    OP_LOOP  = 4'd6,
    OP_JREG  = 4'd7,
    OP_LDAR  = 4'd8,
    OP_CJREG = 4'd9
  } op_e;

  logic [ADDR_W-1:0] upc, cnt, ar, y_last;
  logic [SP_W-1:0]   sp;
  logic              stk_err;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic              c;
  logic [ADDR_W-1:0] sel, y_new;
  logic              do_push, do_pop, stk_fault, cnt_ld, cnt_dec, ar_ld;
  logic [IDX_W-1:0]  push_idx, top_idx;

  assign push_idx = IDX_W'(sp);
  assign top_idx  = IDX_W'(sp - 1'b1);

  always_comb begin
    c         = bus.conds[bus.cond_sel] ^ bus.cond_pol;
    sel       = upc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    stk_fault = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    ar_ld     = 1'b0;
    case (op_e'(bus.op))
      OP_JMP:   sel = bus.din;
      OP_CJMP:  if (c) sel = bus.din;
      OP_CALL: begin
        if (c) begin
          sel = bus.din;
          // A full stack still takes the jump; only the return address is lost.
          if (sp == SP_W'(STACK_DEPTH)) stk_fault = 1'b1;
          else                          do_push   = 1'b1;
        end
      end
      OP_RET: begin
        if (c) begin
          if (sp == '0) begin
            sel       = RESET_ADDR;
            stk_fault = 1'b1;
          end else begin
            sel    = stack[top_idx];
            do_pop = 1'b1;
          end
        end
      end
      OP_LDCNT: cnt_ld = 1'b1;
      OP_LOOP: begin
        if (cnt != '0) begin
          sel     = bus.din;
          cnt_dec = 1'b1;
        end
      end
      OP_JREG:  sel = ar;
      OP_LDAR:  ar_ld = 1'b1;
      OP_CJREG: if (c) sel = ar;
      default:  sel = upc;
    endcase
    y_new = sel | bus.orin;
  end

  // hold replays the previous address verbatim, without re-applying orin
  assign bus.y       = reset ? RESET_ADDR : (bus.hold ? y_last : y_new);
  assign bus.stk_err = stk_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc     <= RESET_ADDR + 1'b1;
      sp      <= '0;
      cnt     <= '0;
      ar      <= '0;
      y_last  <= RESET_ADDR;
      stk_err <= 1'b0;
    end else if (!bus.hold) begin
      upc    <= y_new + 1'b1;
      y_last <= y_new;
      if (do_push)   sp      <= sp + 1'b1;
      if (do_pop)    sp      <= sp - 1'b1;
      if (stk_fault) stk_err <= 1'b1;
      if (cnt_ld)    cnt     <= bus.din;
      if (cnt_dec)   cnt     <= cnt - 1'b1;
      if (ar_ld)     ar      <= bus.rin;
    end
  end

  // Stack storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && !bus.hold && do_push) stack[push_idx] <= upc;
  end

`ifdef MICROSEQ_PERF_EN
  logic [31:0] instr_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     instr_cycles <= '0;
    else if (!bus.hold) begin
      if (y_new == FETCH_ADDR)     instr_cycles <= 32'd1;
      else                         instr_cycles <= instr_cycles + 32'd1;
    end
  end

  assign bus.instr_cycles = instr_cycles;
`endif
endmodule
